// File: rtl/io_arb_pkg.sv
// rtl/io_arb_pkg.sv - shared types and constants for the IO bus arbiter
//
// Holds the arbiter FSM state encoding, the shared bus width, and the default
// port count and hold limit. Also holds the helper that sizes port-index fields.
// Imported by io_rr_pick and io_bus_arbiter.
package io_arb_pkg;

  localparam int IO_BUS_WIDTH     = 16;
  localparam int IO_ARB_NUM_PORTS = 4;
  localparam int IO_ARB_MAX_HOLD  = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Width of a port index; kept at least one bit for a single-port build.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_rr_pick.sv
// rtl/io_rr_pick.sv - combinational round-robin winner selection
//
// Searches upward from (last+1) mod NUM_PORTS and returns the first
// requesting port.
// Ports:
//   req        in   NUM_PORTS  request vector
//   last       in   IW         index of the previous grant
//   win_onehot out  NUM_PORTS  one-hot winner (all zero if no request)
//   win_idx    out  IW         index of the winner
module io_rr_pick
  import io_arb_pkg::*;
#(
  parameter int NUM_PORTS = IO_ARB_NUM_PORTS,
  parameter int IW        = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        last,
  output logic [NUM_PORTS-1:0] win_onehot,
  output logic [IW-1:0]        win_idx
);

  logic          found;
  logic [IW-1:0] idx;

  always_comb begin
    win_onehot = '0;
    win_idx    = '0;
    found      = 1'b0;
    idx        = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx = IW'((int'(last) + 1 + k) % NUM_PORTS);
      if (!found && req[idx]) begin
        found           = 1'b1;
        win_onehot[idx] = 1'b1;
        win_idx         = idx;
      end
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - round-robin owner arbiter for a shared 16-bit IO bus
//
// Four-state FSM (IDLE, GRANT, XFER, RELEASE) hands the bus to one port at a
// time. All outputs are registered: they are decoded from the next state and
// captured alongside it.
// Optional feature macro: IO_ARB_TIMEOUT_EN bounds XFER to MAX_HOLD cycles.
// Without it, XFER is unbounded and timeout is tied low.
// Ports:
//   clk      in   1          clock, rising edge
//   reset    in   1          asynchronous, active-high
//   req      in   NUM_PORTS  per-port request, held for the whole transfer
//   dir      in   NUM_PORTS  1 = bus-to-port (latch), 0 = port-to-bus (drive)
//   grant    out  NUM_PORTS  one-hot bus owner, zero when idle
//   io_en    out  NUM_PORTS  per-port latch strobe
//   io_out   out  NUM_PORTS  per-port output enable
//   ack      out  NUM_PORTS  per-port data-phase indicator
//   busy     out  1          high whenever the FSM is not in IDLE
//   timeout  out  1          one-cycle pulse on forced release
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_PORTS = IO_ARB_NUM_PORTS,
  parameter int MAX_HOLD  = IO_ARB_MAX_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] dir,
  output logic [NUM_PORTS-1:0] grant,
  output logic [NUM_PORTS-1:0] io_en,
  output logic [NUM_PORTS-1:0] io_out,
  output logic [NUM_PORTS-1:0] ack,
  output logic                 busy,
  output logic                 timeout
);

  localparam int IW = idx_width(NUM_PORTS);

  arb_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0] own_q, own_d;
  logic [IW-1:0]        own_idx_q, own_idx_d;
  logic [IW-1:0]        last_q, last_d;
  logic                 dir_q, dir_d;
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] io_en_q, io_en_d;
  logic [NUM_PORTS-1:0] io_out_q, io_out_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic [NUM_PORTS-1:0] win_onehot;
  logic [IW-1:0]        win_idx;
  logic                 own_req;

`ifdef IO_ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  logic [HW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  io_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .IW        (IW)
  ) u_pick (
    .req        (req),
    .last       (last_q),
    .win_onehot (win_onehot),
    .win_idx    (win_idx)
  );

  // Only the owner's request matters once the bus is granted.
  assign own_req = |(req & own_q);

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    own_idx_d = own_idx_q;
    dir_d     = dir_q;
    last_d    = last_q;
`ifdef IO_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d   = ST_GRANT;
          own_d     = win_onehot;
          own_idx_d = win_idx;
          dir_d     = dir[win_idx];
        end
      end
      ST_GRANT: begin
        state_d = ST_XFER;
`ifdef IO_ARB_TIMEOUT_EN
        hold_d  = '0;
`endif
      end
      ST_XFER: begin
        if (!own_req) begin
          state_d = ST_RELEASE;
          last_d  = own_idx_q;
        end
`ifdef IO_ARB_TIMEOUT_EN
        // hold_q counts completed XFER cycles, so this is the MAX_HOLD-th one.
        else if (hold_q == HW'(MAX_HOLD - 1)) begin
          state_d   = ST_RELEASE;
          last_d    = own_idx_q;
          timeout_d = 1'b1;
        end
        hold_d = hold_q + 1'b1;
`endif
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        own_d   = '0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs follow the state being entered so they can be registered.
    grant_d  = '0;
    io_en_d  = '0;
    io_out_d = '0;
    ack_d    = '0;
    busy_d   = (state_d != ST_IDLE);
    case (state_d)
      ST_GRANT: grant_d = own_d;
      ST_XFER: begin
        grant_d = own_d;
        ack_d   = own_d;
        if (dir_d) io_en_d  = own_d;
        else       io_out_d = own_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      own_q     <= '0;
      own_idx_q <= '0;
      last_q    <= IW'(NUM_PORTS - 1);
      dir_q     <= 1'b0;
      grant_q   <= '0;
      io_en_q   <= '0;
      io_out_q  <= '0;
      ack_q     <= '0;
      busy_q    <= 1'b0;
`ifdef IO_ARB_TIMEOUT_EN
      hold_q    <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      own_q     <= own_d;
      own_idx_q <= own_idx_d;
      last_q    <= last_d;
      dir_q     <= dir_d;
      grant_q   <= grant_d;
      io_en_q   <= io_en_d;
      io_out_q  <= io_out_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
`ifdef IO_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
`endif
    end
  end

  assign grant  = grant_q;
  assign io_en  = io_en_q;
  assign io_out = io_out_q;
  assign ack    = ack_q;
  assign busy   = busy_q;
`ifdef IO_ARB_TIMEOUT_EN
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - self-checking bench for io_bus_arbiter
//
// Directed scenarios followed by random requests. Every cycle is compared
// against a transaction-level reference model of the arbiter.
// Honours IO_ARB_TIMEOUT_EN for the expected hold-limit behaviour.
module tb_io_bus_arbiter;

  localparam int N    = 4;
  localparam int MAXH = 4;
`ifdef IO_ARB_TIMEOUT_EN
  localparam bit         TO_EN   = 1'b1;
  localparam logic [3:0] EXP_G7  = 4'b0010;
  localparam logic       EXP_TO5 = 1'b1;
`else
  localparam bit         TO_EN   = 1'b0;
  localparam logic [3:0] EXP_G7  = 4'b1000;
  localparam logic       EXP_TO5 = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] dir;
  logic [N-1:0] grant;
  logic [N-1:0] io_en;
  logic [N-1:0] io_out;
  logic [N-1:0] ack;
  logic         busy;
  logic         timeout;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner (-1 when idle), XFER cycles completed, and a
  // release flag that marks the single dead cycle after a transfer.
  int m_owner;
  int m_xfer;
  int m_last;
  bit m_dir;
  bit m_rel;
  bit m_to;

  io_bus_arbiter #(
    .NUM_PORTS (N),
    .MAX_HOLD  (MAXH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .dir     (dir),
    .grant   (grant),
    .io_en   (io_en),
    .io_out  (io_out),
    .ack     (ack),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_xfer  = 0;
    m_last  = N - 1;
    m_dir   = 1'b0;
    m_rel   = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] d);
    if (m_rel) begin
      m_rel   = 1'b0;
      m_to    = 1'b0;
      m_owner = -1;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (r[p]) begin
          m_owner = p;
          m_dir   = d[p];
          m_xfer  = 0;
          break;
        end
      end
    end else if (m_xfer == 0) begin
      m_xfer = 1;
    end else if (!r[m_owner]) begin
      m_rel  = 1'b1;
      m_last = m_owner;
    end else if (TO_EN && m_xfer == MAXH) begin
      m_rel  = 1'b1;
      m_last = m_owner;
      m_to   = 1'b1;
    end else begin
      m_xfer++;
    end
  endtask

  task automatic check_outputs();
    logic [N-1:0] e_grant, e_en, e_out, e_ack;
    logic         e_busy, e_to;
    e_grant = '0;
    e_en    = '0;
    e_out   = '0;
    e_ack   = '0;
    e_busy  = m_rel || (m_owner >= 0);
    e_to    = m_rel && m_to;
    if (!m_rel && m_owner >= 0) begin
      e_grant = 4'b0001 << m_owner;
      if (m_xfer > 0) begin
        e_ack = e_grant;
        if (m_dir) e_en  = e_grant;
        else       e_out = e_grant;
      end
    end
    chk("grant",   grant,   e_grant);
    chk("io_en",   io_en,   e_en);
    chk("io_out",  io_out,  e_out);
    chk("ack",     ack,     e_ack);
    chk("busy",    busy,    e_busy);
    chk("timeout", timeout, e_to);
  endtask

  // Drive inputs at the falling edge, advance the model, check after the next rise.
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] d);
    req = r;
    dir = d;
    model_step(r, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    dir   = '0;
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b0;
  endtask

  initial begin
    logic [N-1:0] rr_mask;
    logic [N-1:0] r_rand;
    logic [N-1:0] d_rand;

    reset = 1'b1;
    req   = '0;
    dir   = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs();
    reset = 1'b0;

    // Port 0 latching for three data cycles.
    step(4'b0001, 4'b0001);
    chk("s1_grant_c1", grant, 4'b0001);
    for (int i = 0; i < 3; i++) begin
      step(4'b0001, 4'b0001);
      chk("s1_io_en_xfer", io_en, 4'b0001);
    end
    step(4'b0000, 4'b0001);
    chk("s1_release_grant", grant, 4'b0000);
    chk("s1_release_busy", busy, 1'b1);
    step(4'b0000, 4'b0000);
    chk("s1_idle_busy", busy, 1'b0);

    // All ports requesting, each drops its request during GRANT.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 4'b0000);
      chk("rr_order", grant, 4'b0001 << (k % N));
      rr_mask = 4'b1111 & ~(4'b0001 << (k % N));
      step(rr_mask, 4'b0000);
      step(rr_mask, 4'b0000);
      step(4'b1111, 4'b0000);
    end
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Port 2 driving the bus.
    for (int i = 0; i < 3; i++) step(4'b0100, 4'b0000);
    chk("s3_io_out", io_out, 4'b0100);
    chk("s3_io_en", io_en, 4'b0000);
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000);

    // Asynchronous reset in the middle of a port 1 transfer.
    do_reset();
    step(4'b0010, 4'b0010);
    step(4'b0010, 4'b0010);
    chk("s4_pre_io_en", io_en, 4'b0010);
    #2 reset = 1'b1;
    #1;
    chk("s4_async_grant", grant, 4'b0000);
    chk("s4_async_io_en", io_en, 4'b0000);
    chk("s4_async_io_out", io_out, 4'b0000);
    chk("s4_async_ack", ack, 4'b0000);
    chk("s4_async_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    step(4'b0010, 4'b0010);
    chk("s4_first_come", grant, 4'b0010);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    do_reset();
    step(4'b0011, 4'b0000);
    chk("s4_tie_port0", grant, 4'b0001);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0000);

    // Port 3 holds on while port 1 waits.
    do_reset();
    step(4'b1000, 4'b0000);
    for (int i = 1; i <= 9; i++) begin
      step(4'b1010, 4'b0000);
      if (i == 5) chk("s5_timeout_pulse", timeout, EXP_TO5);
      if (i == 7) chk("s5_regrant", grant, EXP_G7);
    end
    for (int i = 0; i < 8; i++) step(4'b0000, 4'b0000);

    // Random requests with occasional reuse of the previous pattern.
    do_reset();
    r_rand = '0;
    d_rand = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        r_rand = N'($urandom);
        d_rand = N'($urandom);
      end
      step(r_rand, d_rand);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_bus_arbiter.md
IO_BUS_ARBITER -- requirements
Module: io_bus_arbiter

Interface
- REQ-001 The block SHALL expose parameters (name, default, meaning) as follows:
  - NUM_PORTS, 4, number of IO ports sharing the 16-bit bus.
  - MAX_HOLD, 16, maximum consecutive XFER cycles per grant (timeout build only).
- REQ-002 The block SHALL expose ports (name, direction, width, meaning) as follows:
  - clk, input, 1, clock; all state updates on its rising edge.
  - reset, input, 1, asynchronous, active-high.
  - req, input, NUM_PORTS, per-port bus request; held high for the whole transfer.
  - dir, input, NUM_PORTS, per-port direction: 1 = bus-to-port (latch), 0 = port-to-bus (drive).
  - grant, output, NUM_PORTS, one-hot owner of the bus; all zero when idle.
  - io_en, output, NUM_PORTS, per-port latch strobe (port captures the bus).
  - io_out, output, NUM_PORTS, per-port output enable (port drives the bus).
  - ack, output, NUM_PORTS, per-port data-phase indicator.
  - busy, output, 1, high in any state other than IDLE.
  - timeout, output, 1, one-cycle pulse on forced release.

Function
- REQ-003 All outputs SHALL be registered; no combinational path from inputs to outputs.
- REQ-004 The FSM SHALL have exactly four states, IDLE, GRANT, XFER and RELEASE; busy SHALL be low only in IDLE.
- REQ-005 In IDLE with any req bit high, the FSM SHALL select a winner and enter GRANT on the next edge.
- REQ-005a With no req bit high, IDLE SHALL hold.
- REQ-006 The winner SHALL be the first requesting index found by searching upward from (last+1) mod NUM_PORTS.
  - last is the index of the previous grant.
- REQ-007 GRANT SHALL last exactly one cycle.
  - grant[w] = 1; io_en, io_out and ack = 0 (bus turnaround).
  - The FSM SHALL then enter XFER.
- REQ-008 Every XFER cycle SHALL assert grant[w] = 1 and ack[w] = 1.
  - io_en[w] = 1 if dir[w] = 1; io_out[w] = 1 if dir[w] = 0.
  - All other bits of these outputs SHALL be 0.
- REQ-009 dir[w] SHALL be sampled in IDLE at selection and held constant for the entire grant.
- REQ-010 XFER SHALL be left for RELEASE on the edge after req[w] is sampled low.
  - The minimum data phase SHALL therefore be one cycle.
- REQ-011 RELEASE SHALL last exactly one cycle with grant, io_en, io_out and ack all zero, then return to IDLE.
  - last SHALL be updated to w on entry to RELEASE.
- REQ-012 io_en and io_out SHALL never both be nonzero in the same cycle.
- REQ-012a At most one bit of io_out SHALL be set in any cycle.
- REQ-013 req changes on non-granted ports during GRANT, XFER or RELEASE SHALL have no effect until the next IDLE.
- REQ-014 req[w] dropping during GRANT SHALL still yield one XFER cycle, then RELEASE.
- REQ-015 Minimum grant-to-grant spacing SHALL be 4 cycles: GRANT, XFER, RELEASE, IDLE.

Reset
- REQ-016 reset high SHALL immediately force the following, regardless of clk:
  - state = IDLE; grant, io_en, io_out, ack, busy and timeout all 0.
  - last = NUM_PORTS-1, so port 0 wins first.
- REQ-017 A reset asserted mid-XFER SHALL drop all strobes asynchronously; no partial cycle SHALL be extended.

Configuration
- REQ-018 With IO_ARB_TIMEOUT_EN defined, the block SHALL apply a hold limit in XFER:
  - A hold counter SHALL count XFER cycles, cleared in GRANT.
  - When the counter reaches MAX_HOLD with req[w] still high, the FSM SHALL enter RELEASE and pulse timeout for one cycle in RELEASE.
  - The round-robin pointer SHALL advance, so a still-requesting port w SHALL be re-granted only if no other port requests.
- REQ-019 Without IO_ARB_TIMEOUT_EN, the counter and timeout logic SHALL be absent; timeout SHALL be tied to 0 and XFER SHALL be unbounded.

Structure
- REQ-020 A shared package io_arb_pkg SHALL hold:
  - the state encoding (IDLE, GRANT, XFER, RELEASE);
  - the bus width constant (16);
  - the default NUM_PORTS and MAX_HOLD.
- REQ-021 Winner selection SHALL be a combinational sub-module io_rr_pick.
  - Inputs: req and last. Output: one-hot winner plus its index.

Verification
- REQ-022 The bench SHALL cover at least these directed scenarios:
  - Reset, then req = 0001 with dir[0] = 1 held 3 cycles:
    - grant = 0001 from cycle 1; io_en[0] high for cycles 2-4; RELEASE at cycle 5; io_out = 0 throughout.
  - req = 1111 held continuously, 1-cycle transfers:
    - grant order 0, 1, 2, 3, 0; spacing 4 cycles.
  - req = 0100 with dir[2] = 0:
    - io_out = 0100 during XFER only; io_en = 0000 throughout.
  - Reset asserted during XFER of port 1:
    - grant, io_en and io_out go to 0 without waiting for a clk edge.
    - After release, req = 0010 is granted first-come from IDLE; port 0 would still win a tie.
  - Timeout build, MAX_HOLD = 4, req[3] held high while req[1] is high:
    - exactly 4 XFER cycles, then timeout pulses, then port 1 is granted.
  - Non-timeout build, same stimulus:
    - port 3 holds the grant indefinitely; timeout stays 0.
